// File: rtl/seq_pattern_gen_pkg.sv
// Shared types and constants for the serial pattern generator and its gap-noise LFSR.
package seq_pattern_gen_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_e;

   localparam int DEF_PAT_W = 4;
   localparam int DEF_CNT_W = 4;
   localparam int DEF_GAP_W = 3;

   // x^7 + x^6 + 1: feedback from the two top stages, output taken from stage 0
   localparam int               LFSR_W     = 7;
   localparam int               LFSR_TAP_A = 6;
   localparam int               LFSR_TAP_B = 5;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h01;

endpackage

// File: rtl/seq_pattern_lfsr.sv
// 7-bit Fibonacci LFSR with enable; supplies junk bits for inter-frame gaps.
module seq_pattern_lfsr
   import seq_pattern_gen_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic lfsr_bit
);

   logic [LFSR_W-1:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (en) lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
   end

   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign lfsr_bit = lfsr_q[0];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter with repeat count and inter-repetition gap.
// Define SEQ_PATTERN_GEN_GAP_NOISE_EN to fill gap cycles with LFSR noise instead of 0.
module seq_pattern_gen
   import seq_pattern_gen_pkg::*;
#(
   parameter int PAT_W     = DEF_PAT_W,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int GAP_W     = DEF_GAP_W,
   parameter bit MSB_FIRST = 1'b1
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] rep_cnt,
   input  logic [GAP_W-1:0] gap,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             done
);

   localparam int               BIT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

   state_e             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d, pat_in_ord;
   logic [CNT_W-1:0]   rep_q, rep_d;
   logic [GAP_W-1:0]   gap_q, gap_d, gcnt_q, gcnt_d;
   logic [BIT_W-1:0]   bit_q, bit_d, nxt_bit;
   logic               x_q, x_d, xv_q, xv_d, busy_q, busy_d, done_q, done_d;
   logic               noise_bit;

`ifdef SEQ_PATTERN_GEN_GAP_NOISE_EN
   logic noise_en;

   // Advance only on edges that load a gap bit, so each gap cycle shows a fresh LFSR bit
   assign noise_en = (state_d == GAP);

   seq_pattern_lfsr u_lfsr (
      .clk      (clk),
      .reset    (reset),
      .en       (noise_en),
      .lfsr_bit (noise_bit)
   );
`else
   assign noise_bit = 1'b0;
`endif

   // Pattern is stored in transmit order so bit index i is always the i-th bit sent
   always_comb begin
      pat_in_ord = pattern;
      if (MSB_FIRST) begin
         for (int unsigned i = 0; i < PAT_W; i++) pat_in_ord[i] = pattern[PAT_W-1-i];
      end
   end

   assign nxt_bit = bit_q + 1'b1;

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      rep_d   = rep_q;
      gap_d   = gap_q;
      gcnt_d  = gcnt_q;
      bit_d   = bit_q;
      x_d     = 1'b0;
      xv_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               pat_d   = pat_in_ord;
               rep_d   = (rep_cnt == '0) ? CNT_W'(1) : rep_cnt;
               gap_d   = gap;
               bit_d   = '0;
               state_d = SHIFT;
               x_d     = pat_in_ord[0];
               xv_d    = 1'b1;
               busy_d  = 1'b1;
            end
         end
         SHIFT: begin
            if (bit_q != LAST_BIT) begin
               bit_d  = nxt_bit;
               x_d    = pat_q[nxt_bit];
               xv_d   = 1'b1;
               busy_d = 1'b1;
            end else if (rep_q > CNT_W'(1)) begin
               rep_d  = rep_q - CNT_W'(1);
               bit_d  = '0;
               busy_d = 1'b1;
               if (gap_q != '0) begin
                  state_d = GAP;
                  gcnt_d  = gap_q - GAP_W'(1);
                  x_d     = noise_bit;
               end else begin
                  x_d  = pat_q[0];
                  xv_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
               rep_d   = '0;
               bit_d   = '0;
               done_d  = 1'b1;
            end
         end
         GAP: begin
            busy_d = 1'b1;
            if (gcnt_q == '0) begin
               state_d = SHIFT;
               x_d     = pat_q[0];
               xv_d    = 1'b1;
            end else begin
               gcnt_d = gcnt_q - GAP_W'(1);
               x_d    = noise_bit;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pat_q   <= '0;
         rep_q   <= '0;
         gap_q   <= '0;
         gcnt_q  <= '0;
         bit_q   <= '0;
         x_q     <= 1'b0;
         xv_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         rep_q   <= rep_d;
         gap_q   <= gap_d;
         gcnt_q  <= gcnt_d;
         bit_q   <= bit_d;
         x_q     <= x_d;
         xv_q    <= xv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign x       = x_q;
   assign x_valid = xv_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen (default parameters, MSB first).
module tb_seq_pattern_gen;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] pattern = '0;
   logic [3:0] rep_cnt = '0;
   logic [2:0] gap = '0;
   logic       x, x_valid, busy, done;

   int checks = 0;
   int errors = 0;

`ifdef SEQ_PATTERN_GEN_GAP_NOISE_EN
   logic [2:0] gap_exp = 3'b100;
`else
   logic [2:0] gap_exp = 3'b000;
`endif

   seq_pattern_gen #(.PAT_W(4), .CNT_W(4), .GAP_W(3), .MSB_FIRST(1'b1)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .pattern (pattern),
      .rep_cnt (rep_cnt),
      .gap     (gap),
      .x       (x),
      .x_valid (x_valid),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic expect_cycle(input string tag, input logic ex, input logic exv,
                               input logic eb, input logic ed);
      @(negedge clk);
      chk({tag, ".x"}, x, ex);
      chk({tag, ".x_valid"}, x_valid, exv);
      chk({tag, ".busy"}, busy, eb);
      chk({tag, ".done"}, done, ed);
   endtask

   task automatic start_job(input logic [3:0] p, input logic [3:0] r, input logic [2:0] g);
      pattern = p;
      rep_cnt = r;
      gap     = g;
      start   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic exp_frame(input string tag, input logic [3:0] bits);
      for (int unsigned i = 0; i < 4; i++) begin
         logic [1:0] k;
         k = 2'(3 - i);
         expect_cycle(tag, bits[k], 1'b1, 1'b1, 1'b0);
      end
   endtask

   task automatic exp_gap(input string tag, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         logic [1:0] k;
         k = 2'(2 - i);
         expect_cycle(tag, gap_exp[k], 1'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst.x", x, 1'b0);
      chk("rst.x_valid", x_valid, 1'b0);
      chk("rst.busy", busy, 1'b0);
      chk("rst.done", done, 1'b0);
      reset = 1'b0;
      expect_cycle("idle", 1'b0, 1'b0, 1'b0, 1'b0);

      // Single frame 1101
      start_job(4'b1101, 4'd1, 3'd0);
      exp_frame("single", 4'b1101);
      expect_cycle("single_done", 1'b0, 1'b0, 1'b0, 1'b1);
      expect_cycle("single_after", 1'b0, 1'b0, 1'b0, 1'b0);

      // Three contiguous repetitions, no gap
      start_job(4'b1101, 4'd3, 3'd0);
      exp_frame("rep3_a", 4'b1101);
      exp_frame("rep3_b", 4'b1101);
      exp_frame("rep3_c", 4'b1101);
      expect_cycle("rep3_done", 1'b0, 1'b0, 1'b0, 1'b1);

      // Two repetitions with a 2-cycle gap
      do_reset();
      start_job(4'b0110, 4'd2, 3'd2);
      exp_frame("gap2_a", 4'b0110);
      exp_gap("gap2_g", 2);
      exp_frame("gap2_b", 4'b0110);
      expect_cycle("gap2_done", 1'b0, 1'b0, 1'b0, 1'b1);

      // Start while busy is ignored; start in the done cycle is accepted
      start_job(4'b1101, 4'd1, 3'd0);
      expect_cycle("ign_b0", 1'b1, 1'b1, 1'b1, 1'b0);
      pattern = 4'b1111;
      rep_cnt = 4'd5;
      gap     = 3'd3;
      start   = 1'b1;
      expect_cycle("ign_b1", 1'b1, 1'b1, 1'b1, 1'b0);
      expect_cycle("ign_b2", 1'b0, 1'b1, 1'b1, 1'b0);
      expect_cycle("ign_b3", 1'b1, 1'b1, 1'b1, 1'b0);
      expect_cycle("ign_done", 1'b0, 1'b0, 1'b0, 1'b1);
      start_job(4'b0011, 4'd1, 3'd0);
      exp_frame("b2b", 4'b0011);
      expect_cycle("b2b_done", 1'b0, 1'b0, 1'b0, 1'b1);

      // Reset mid-job: outputs clear, no done pulse
      start_job(4'b1101, 4'd2, 3'd0);
      expect_cycle("mrst_c1", 1'b1, 1'b1, 1'b1, 1'b0);
      expect_cycle("mrst_c2", 1'b1, 1'b1, 1'b1, 1'b0);
      expect_cycle("mrst_c3", 1'b0, 1'b1, 1'b1, 1'b0);
      reset = 1'b1;
      expect_cycle("mrst_c4", 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      for (int unsigned i = 0; i < 6; i++) expect_cycle("mrst_quiet", 1'b0, 1'b0, 1'b0, 1'b0);

      // rep_cnt=0 behaves as a single repetition
      start_job(4'b1011, 4'd0, 3'd5);
      exp_frame("rep0", 4'b1011);
      expect_cycle("rep0_done", 1'b0, 1'b0, 1'b0, 1'b1);

      // Maximum repeat count is sent in full
      start_job(4'b1000, 4'd15, 3'd0);
      for (int unsigned r = 0; r < 15; r++) exp_frame("rep15", 4'b1000);
      expect_cycle("rep15_done", 1'b0, 1'b0, 1'b0, 1'b1);

      // Three-cycle gap, checked against fresh LFSR state
      do_reset();
      start_job(4'b1001, 4'd2, 3'd3);
      exp_frame("gap3_a", 4'b1001);
      exp_gap("gap3_g", 3);
      exp_frame("gap3_b", 4'b1001);
      expect_cycle("gap3_done", 1'b0, 1'b0, 1'b0, 1'b1);
      expect_cycle("gap3_after", 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
